// File: rtl/register_pair_sequencer.sv
// rtl/register_pair_sequencer.sv - register-pair command sequencer in front of the 16-bit RegisterBank port
module register_pair_sequencer #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdOp,
  input  logic [1:0]  cmdDst,
  input  logic [1:0]  cmdSrc,
  input  logic [15:0] cmdImm,
  output logic        done,
  output logic [15:0] result,
  output logic        flagC,
  output logic        flagH,
  output logic        illegal,
  output logic [2:0]  bankRegNum,
  output logic [15:0] bankDataIn16,
  output logic        bankWriteEnable16,
  input  logic [15:0] bankDataOut16
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_DONE} state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_LDS  = 3'd3;
  localparam logic [2:0] OP_LDI  = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;
  localparam logic [1:0] RD_LAST = READ_WAIT[1:0];

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  dst_q, dst_d, src_q, src_d;
  logic [15:0] imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic [15:0] result_q, result_d;
  logic        flag_c_q, flag_c_d, flag_h_q, flag_h_d, illegal_q, illegal_d;

  logic [16:0] sum17;
  logic [12:0] half13;
  logic [15:0] wr_val;
  logic        c_calc, h_calc;

  assign sum17  = {1'b0, a_q} + {1'b0, b_q};
  assign half13 = {1'b0, a_q[11:0]} + {1'b0, b_q[11:0]};

  // Value for the dst write; operands are stable once the reads are done.
  always_comb begin
    wr_val = 16'h0000;
    c_calc = 1'b0;
    h_calc = 1'b0;
    case (op_q)
      OP_INC:  begin wr_val = a_q + 16'd1; c_calc = (a_q == 16'hFFFF); end
      OP_DEC:  begin wr_val = a_q - 16'd1; c_calc = (a_q == 16'h0000); end
      OP_LDS:  wr_val = b_q;
      OP_LDI:  wr_val = imm_q;
      OP_ADD:  begin wr_val = sum17[15:0]; c_calc = sum17[16]; h_calc = half13[12]; end
      OP_SWAP: wr_val = b_q;
      default: wr_val = 16'h0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_d     = src_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flag_c_d  = flag_c_q;
    flag_h_d  = flag_h_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          op_d  = cmdOp;
          dst_d = cmdDst;
          src_d = cmdSrc;
          imm_d = cmdImm;
          cnt_d = 2'd0;
          case (cmdOp)
            OP_INC, OP_DEC, OP_ADD, OP_SWAP: state_d = S_RD_A;
            OP_LDS:                          state_d = S_RD_B;
            OP_LDI:                          state_d = S_WR_A;
            default:                         state_d = S_DONE;
          endcase
        end
      end
      S_RD_A: begin
        if (cnt_q == RD_LAST) begin
          a_d     = bankDataOut16;
          cnt_d   = 2'd0;
          state_d = (op_q == OP_ADD || op_q == OP_SWAP) ? S_RD_B : S_WR_A;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RD_B: begin
        if (cnt_q == RD_LAST) begin
          b_d     = bankDataOut16;
          cnt_d   = 2'd0;
          state_d = S_WR_A;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR_A:  state_d = (op_q == OP_SWAP) ? S_WR_B : S_DONE;
      S_WR_B:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // NOP/illegal enter DONE straight from IDLE, before op_q holds the new op.
    if (state_d == S_DONE && state_q != S_DONE) begin
      if (state_q == S_IDLE) begin
        result_d  = 16'h0000;
        flag_c_d  = 1'b0;
        flag_h_d  = 1'b0;
        illegal_d = (cmdOp == OP_ILL);
      end else begin
        result_d  = wr_val;
        flag_c_d  = c_calc;
        flag_h_d  = h_calc;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      op_q      <= OP_NOP;
      dst_q     <= 2'd0;
      src_q     <= 2'd0;
      imm_q     <= 16'h0000;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      result_q  <= 16'h0000;
      flag_c_q  <= 1'b0;
      flag_h_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flag_c_q  <= flag_c_d;
      flag_h_q  <= flag_h_d;
      illegal_q <= illegal_d;
    end
  end

  assign cmdReady = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign flagC    = flag_c_q;
  assign flagH    = flag_h_q;
  assign illegal  = illegal_q;

  assign bankRegNum   = {((state_q == S_RD_B) || (state_q == S_WR_B)) ? src_q : dst_q, 1'b0};
  assign bankDataIn16 = (state_q == S_WR_A) ? wr_val :
                        (state_q == S_WR_B) ? a_q    : 16'h0000;
  // Gated by reset so a write caught mid-flight is never committed.
  assign bankWriteEnable16 = reset && ((state_q == S_WR_A) || (state_q == S_WR_B));

endmodule
